// File: rtl/cdb_age_arbiter.sv
// Oldest-first CDB writeback arbiter: one holding register per FU port feeding a registered CDB stage.
// Define CDB_ARB_STARVE_EN to build per-port starvation counters that force a grant at STARVE_MAX.
module cdb_age_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREQ       = 4,
    parameter int unsigned ROB_IDX_W  = 6,
    parameter int unsigned PD_W       = 10,
    parameter int unsigned STARVE_MAX = 8,
    localparam int unsigned SrcW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic [ROB_IDX_W-1:0]      rob_head_i,
    input  logic [NREQ-1:0]           req_valid_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [NREQ*XLEN-1:0]      req_value_i,
    input  logic [NREQ*PD_W-1:0]      req_pd_i,
    input  logic [NREQ*ROB_IDX_W-1:0] req_rob_i,
    input  logic [NREQ-1:0]           req_we_i,
    output logic                      cdb_valid_o,
    input  logic                      cdb_ready_i,
    output logic [XLEN-1:0]           cdb_value_o,
    output logic [PD_W-1:0]           cdb_pd_o,
    output logic [ROB_IDX_W-1:0]      cdb_rob_o,
    output logic                      cdb_we_o,
    output logic [SrcW-1:0]           cdb_src_o
);

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("STARVE_MAX must be at least 1");
    end

    logic [NREQ-1:0]      hold_v_q, hold_v_d;
    logic [XLEN-1:0]      hold_value_q [NREQ];
    logic [XLEN-1:0]      hold_value_d [NREQ];
    logic [PD_W-1:0]      hold_pd_q [NREQ];
    logic [PD_W-1:0]      hold_pd_d [NREQ];
    logic [ROB_IDX_W-1:0] hold_rob_q [NREQ];
    logic [ROB_IDX_W-1:0] hold_rob_d [NREQ];
    logic [NREQ-1:0]      hold_we_q, hold_we_d;

    logic                 out_v_q, out_v_d;
    logic [XLEN-1:0]      out_value_q, out_value_d;
    logic [PD_W-1:0]      out_pd_q, out_pd_d;
    logic [ROB_IDX_W-1:0] out_rob_q, out_rob_d;
    logic                 out_we_q, out_we_d;
    logic [SrcW-1:0]      out_src_q, out_src_d;

    logic                 out_adv, out_load, any_hold, found;
    logic [ROB_IDX_W-1:0] age, best_age;
    logic [SrcW-1:0]      sel;
    logic [NREQ-1:0]      grant;

`ifdef CDB_ARB_STARVE_EN
    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    logic [CntW-1:0] cnt_q [NREQ];
    logic [CntW-1:0] cnt_d [NREQ];
    logic            starve_hit;
`endif

    assign out_adv  = !out_v_q || cdb_ready_i;
    assign any_hold = |hold_v_q;
    assign out_load = out_adv && any_hold && !flush_i && !rst;

    // Age is the modular distance from the ROB head, so unsigned subtraction handles wrap.
    always_comb begin
        found    = 1'b0;
        best_age = '0;
        age      = '0;
        sel      = '0;
        for (int i = 0; i < NREQ; i++) begin
            age = hold_rob_q[i] - rob_head_i;
            if (hold_v_q[i] && (!found || age < best_age)) begin
                found    = 1'b1;
                best_age = age;
                sel      = SrcW'(i);
            end
        end
`ifdef CDB_ARB_STARVE_EN
        starve_hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (hold_v_q[i] && cnt_q[i] == CntW'(STARVE_MAX) && !starve_hit) begin
                starve_hit = 1'b1;
                sel        = SrcW'(i);
            end
        end
`endif
    end

    always_comb begin
        grant       = '0;
        req_ready_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i]       = out_load && (sel == SrcW'(i));
            req_ready_o[i] = !rst && !flush_i && (!hold_v_q[i] || grant[i]);
        end
    end

    always_comb begin
        hold_v_d     = hold_v_q;
        hold_value_d = hold_value_q;
        hold_pd_d    = hold_pd_q;
        hold_rob_d   = hold_rob_q;
        hold_we_d    = hold_we_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) hold_v_d[i] = 1'b0;
            // A granted slot may refill in the same cycle.
            if (req_valid_i[i] && req_ready_o[i]) begin
                hold_v_d[i]     = 1'b1;
                hold_value_d[i] = req_value_i[i*XLEN +: XLEN];
                hold_pd_d[i]    = req_pd_i[i*PD_W +: PD_W];
                hold_rob_d[i]   = req_rob_i[i*ROB_IDX_W +: ROB_IDX_W];
                hold_we_d[i]    = req_we_i[i];
            end
        end
        if (flush_i) hold_v_d = '0;
    end

    always_comb begin
        out_v_d     = out_v_q;
        out_value_d = out_value_q;
        out_pd_d    = out_pd_q;
        out_rob_d   = out_rob_q;
        out_we_d    = out_we_q;
        out_src_d   = out_src_q;
        if (out_adv) begin
            out_v_d = out_load;
            if (out_load) begin
                out_value_d = hold_value_q[sel];
                out_pd_d    = hold_pd_q[sel];
                out_rob_d   = hold_rob_q[sel];
                out_we_d    = hold_we_q[sel];
                out_src_d   = sel;
            end
        end
        if (flush_i) out_v_d = 1'b0;
    end

`ifdef CDB_ARB_STARVE_EN
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush_i || !hold_v_q[i] || grant[i]) begin
                cnt_d[i] = '0;
            end else if (out_adv && cnt_q[i] != CntW'(STARVE_MAX)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v_q    <= '0;
            out_v_q     <= 1'b0;
            out_value_q <= '0;
            out_pd_q    <= '0;
            out_rob_q   <= '0;
            out_we_q    <= 1'b0;
            out_src_q   <= '0;
        end else begin
            hold_v_q    <= hold_v_d;
            out_v_q     <= out_v_d;
            out_value_q <= out_value_d;
            out_pd_q    <= out_pd_d;
            out_rob_q   <= out_rob_d;
            out_we_q    <= out_we_d;
            out_src_q   <= out_src_d;
        end
    end

    // Payload is qualified by hold_v_q, so it needs no reset.
    always_ff @(posedge clk) begin
        hold_value_q <= hold_value_d;
        hold_pd_q    <= hold_pd_d;
        hold_rob_q   <= hold_rob_d;
        hold_we_q    <= hold_we_d;
    end

    assign cdb_valid_o = out_v_q;
    assign cdb_value_o = out_value_q;
    assign cdb_pd_o    = out_pd_q;
    assign cdb_rob_o   = out_rob_q;
    assign cdb_we_o    = out_we_q;
    assign cdb_src_o   = out_src_q;

endmodule

// File: tb/tb_cdb_age_arbiter.sv
// Bench for cdb_age_arbiter: vector table, directed corner sequences and a random run against a
// behavioural model of held results and the output slot.
module tb_cdb_age_arbiter;
    localparam int STARVE = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic [5:0]   rob_head = '0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_value = '0;
    logic [39:0]  req_pd = '0;
    logic [23:0]  req_rob = '0;
    logic [3:0]   req_we = '0;
    logic         cdb_valid;
    logic         cdb_ready = 1'b0;
    logic [31:0]  cdb_value;
    logic [9:0]   cdb_pd;
    logic [5:0]   cdb_rob;
    logic         cdb_we;
    logic [1:0]   cdb_src;

    always #5 clk = ~clk;

    cdb_age_arbiter #(
        .XLEN(32), .NREQ(4), .ROB_IDX_W(6), .PD_W(10), .STARVE_MAX(STARVE)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .rob_head_i(rob_head),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_value_i(req_value),
        .req_pd_i(req_pd), .req_rob_i(req_rob), .req_we_i(req_we),
        .cdb_valid_o(cdb_valid), .cdb_ready_i(cdb_ready), .cdb_value_o(cdb_value),
        .cdb_pd_o(cdb_pd), .cdb_rob_o(cdb_rob), .cdb_we_o(cdb_we), .cdb_src_o(cdb_src)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what each port holds and what sits in the output slot.
    bit          m_live = 0;
    bit          m_hv [4];
    logic [31:0] m_val [4];
    logic [9:0]  m_pd [4];
    logic [5:0]  m_rob [4];
    logic        m_we [4];
    bit          m_ov = 0;
    logic [31:0] m_oval;
    logic [9:0]  m_opd;
    logic [5:0]  m_orob;
    logic        m_owe;
    int          m_osrc;
`ifdef CDB_ARB_STARVE_EN
    int          m_cnt [4];
`endif

    function automatic int age_of(input int p);
        return (int'(m_rob[p]) - int'(rob_head) + 64) % 64;
    endfunction

    function automatic int winner();
        int w = -1;
`ifdef CDB_ARB_STARVE_EN
        for (int i = 0; i < 4; i++) if (m_hv[i] && m_cnt[i] >= STARVE) return i;
`endif
        for (int i = 0; i < 4; i++) if (m_hv[i] && (w < 0 || age_of(i) < age_of(w))) w = i;
        return w;
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r = '0;
        int w;
        if (rst || flush) return 4'b0000;
        w = (!m_ov || cdb_ready) ? winner() : -1;
        for (int i = 0; i < 4; i++) r[i] = !m_hv[i] || (i == w);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_hv[i] = 0;
`ifdef CDB_ARB_STARVE_EN
            m_cnt[i] = 0;
`endif
        end
        m_ov = 0;
    endtask

    task automatic model_check();
        if (!m_live) return;
        chk("cdb_valid", 64'(cdb_valid), 64'(m_ov));
        if (m_ov) begin
            chk("cdb_value", 64'(cdb_value), 64'(m_oval));
            chk("cdb_pd", 64'(cdb_pd), 64'(m_opd));
            chk("cdb_rob", 64'(cdb_rob), 64'(m_orob));
            chk("cdb_we", 64'(cdb_we), 64'(m_owe));
            chk("cdb_src", 64'(cdb_src), 64'(m_osrc));
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready()));
    endtask

    task automatic model_next();
        int w;
        bit adv;
        logic [3:0] rdy;
        if (rst) begin
            model_clear();
            m_live = 1;
            return;
        end
        adv = !m_ov || cdb_ready;
        w   = (adv && !flush) ? winner() : -1;
        rdy = exp_ready();
        if (flush) begin
            model_clear();
            return;
        end
        if (adv) begin
            m_ov = (w >= 0);
            if (w >= 0) begin
                m_oval = m_val[w]; m_opd = m_pd[w]; m_orob = m_rob[w];
                m_owe = m_we[w]; m_osrc = w;
            end
        end
`ifdef CDB_ARB_STARVE_EN
        for (int i = 0; i < 4; i++) begin
            if (!m_hv[i] || i == w) m_cnt[i] = 0;
            else if (adv && m_cnt[i] < STARVE) m_cnt[i]++;
        end
`endif
        for (int i = 0; i < 4; i++) begin
            if (i == w) m_hv[i] = 0;
            if (req_valid[i] && rdy[i]) begin
                m_hv[i]  = 1;
                m_val[i] = req_value[i*32 +: 32];
                m_pd[i]  = req_pd[i*10 +: 10];
                m_rob[i] = req_rob[i*6 +: 6];
                m_we[i]  = req_we[i];
            end
        end
    endtask

    // Inputs change 1 time unit after posedge; checks and model stepping happen at negedge.
    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic set_port(input int p, input logic v, input logic [5:0] rob,
                            input logic [31:0] val, input logic [9:0] pd, input logic we);
        req_valid[p]         = v;
        req_rob[p*6 +: 6]    = rob;
        req_value[p*32 +: 32] = val;
        req_pd[p*10 +: 10]   = pd;
        req_we[p]            = we;
    endtask

    typedef struct packed {
        logic [3:0]  vld;
        logic [23:0] robs;
        logic [5:0]  head;
        logic        rdy;
        logic        fl;
        logic        ev;
        logic [5:0]  erob;
        logic [1:0]  esrc;
        logic [3:0]  erdy;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] vld, input logic [5:0] r0, input logic [5:0] r1,
                                input logic [5:0] r2, input logic [5:0] r3, input logic [5:0] head,
                                input logic rdy, input logic fl, input logic ev,
                                input logic [5:0] erob, input logic [1:0] esrc,
                                input logic [3:0] erdy);
        vec_t v;
        v.vld = vld; v.robs = {r3, r2, r1, r0}; v.head = head; v.rdy = rdy; v.fl = fl;
        v.ev = ev; v.erob = erob; v.esrc = esrc; v.erdy = erdy;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [5:0] r;

        // Wrap-around age ordering, head 60
        tbl.push_back(mk(4'b1011, 2, 61, 0, 63, 60, 1, 0, 0, 0, 0, 4'b1111));
        tbl.push_back(mk(4'b0000, 2, 61, 0, 63, 60, 1, 0, 0, 0, 0, 4'b0110));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 60, 1, 0, 1, 61, 1, 4'b1110));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 60, 1, 0, 1, 63, 3, 4'b1111));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 60, 1, 0, 1, 2, 0, 4'b1111));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 60, 1, 0, 0, 0, 0, 4'b1111));
        // Backpressure with all four ports full
        tbl.push_back(mk(4'b1111, 30, 10, 20, 5, 0, 0, 0, 0, 0, 0, 4'b1111));
        tbl.push_back(mk(4'b1000, 0, 0, 0, 40, 0, 0, 0, 0, 0, 0, 4'b1000));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 5, 3, 4'b0000));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 1, 5, 3, 4'b0010));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 1, 10, 1, 4'b0110));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 1, 20, 2, 4'b0111));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 1, 30, 0, 4'b1111));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 1, 40, 3, 4'b1111));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1111));
        // Flush during a stall
        tbl.push_back(mk(4'b1111, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 4'b1111));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(4'b0100, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 4'b1111));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 1, 9, 2, 4'b1111));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1111));
        // Back-to-back refill on port 1
        tbl.push_back(mk(4'b0010, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1111));
        tbl.push_back(mk(4'b0010, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1111));
        tbl.push_back(mk(4'b0010, 0, 3, 0, 0, 0, 1, 0, 1, 1, 1, 4'b1111));
        tbl.push_back(mk(4'b0010, 0, 4, 0, 0, 0, 1, 0, 1, 2, 1, 4'b1111));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 1, 3, 1, 4'b1111));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 1, 4, 1, 4'b1111));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1111));

        // Reset: two cycles
        #1;
        advance();
        settle();
        chk("reset_ready", 64'(req_ready), 64'(0));
        advance();
        rst = 1'b0;
        settle();
        chk("reset_cdb_valid", 64'(cdb_valid), 64'(0));
        chk("reset_cdb_value", 64'(cdb_value), 64'(0));
        chk("reset_cdb_pd", 64'(cdb_pd), 64'(0));
        chk("reset_cdb_rob", 64'(cdb_rob), 64'(0));
        chk("reset_cdb_we", 64'(cdb_we), 64'(0));
        chk("reset_cdb_src", 64'(cdb_src), 64'(0));
        chk("reset_release_ready", 64'(req_ready), 64'(4'b1111));
        advance();

        // Basic latency
        cdb_ready = 1'b1;
        set_port(2, 1, 5, 32'hDEADBEEF, 10'd17, 1);
        settle();
        chk("basic_accept", 64'(req_ready[2]), 64'(1));
        advance();
        set_port(2, 0, 0, 0, 0, 0);
        settle();
        chk("basic_not_early", 64'(cdb_valid), 64'(0));
        advance();
        settle();
        chk("basic_valid", 64'(cdb_valid), 64'(1));
        chk("basic_value", 64'(cdb_value), 64'(32'hDEADBEEF));
        chk("basic_pd", 64'(cdb_pd), 64'(17));
        chk("basic_rob", 64'(cdb_rob), 64'(5));
        chk("basic_we", 64'(cdb_we), 64'(1));
        chk("basic_src", 64'(cdb_src), 64'(2));
        advance();
        tick();

        // Vector table
        foreach (tbl[n]) begin
            rob_head  = tbl[n].head;
            cdb_ready = tbl[n].rdy;
            flush     = tbl[n].fl;
            for (int p = 0; p < 4; p++) begin
                r = tbl[n].robs[p*6 +: 6];
                set_port(p, tbl[n].vld[p], r, 32'hC0DE_0000 | (32'(p) << 8) | 32'(r),
                         10'(r * 4 + 6'(p)), r[0]);
            end
            settle();
            chk($sformatf("vec%0d_valid", n), 64'(cdb_valid), 64'(tbl[n].ev));
            if (tbl[n].ev) begin
                chk($sformatf("vec%0d_rob", n), 64'(cdb_rob), 64'(tbl[n].erob));
                chk($sformatf("vec%0d_src", n), 64'(cdb_src), 64'(tbl[n].esrc));
            end
            chk($sformatf("vec%0d_ready", n), 64'(req_ready), 64'(tbl[n].erdy));
            advance();
        end
        flush = 1'b0;

        // Starvation: port 3 (rob 40) against a port 0 that always refills with an older entry
        rob_head  = 0;
        cdb_ready = 1'b1;
        set_port(3, 1, 40, 32'h3333_0040, 10'd340, 1);
        set_port(0, 1, 10, 32'h0000_0010, 10'd10, 1);
        tick();
        set_port(3, 0, 0, 0, 0, 0);
        seen = 0;
        for (int c = 1; c <= 20; c++) begin
            set_port(0, 1, (c % 2 == 1) ? 6'd5 : 6'd12, 32'(c), 10'(c), 0);
            settle();
            if (seen == 0 && cdb_valid && cdb_src == 2'd3) seen = c;
            advance();
        end
`ifdef CDB_ARB_STARVE_EN
        chk("starve_forced_grant_cycle", 64'(seen), 64'(10));
`else
        chk("no_starve_pure_age", 64'(seen), 64'(0));
`endif
        set_port(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) tick();

        // Reset during a stall drops the stalled entry
        cdb_ready = 1'b0;
        set_port(0, 1, 3, 32'hAAAA_0003, 10'd3, 1);
        set_port(1, 1, 4, 32'hBBBB_0004, 10'd4, 0);
        tick();
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0);
        tick();
        settle();
        chk("stall_before_reset", 64'(cdb_valid), 64'(1));
        advance();
        rst = 1'b1;
        settle();
        chk("reset_mid_stall_ready", 64'(req_ready), 64'(0));
        advance();
        rst = 1'b0;
        settle();
        chk("reset_mid_stall_dropped", 64'(cdb_valid), 64'(0));
        chk("reset_mid_stall_ready_after", 64'(req_ready), 64'(4'b1111));
        advance();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 7) == 0) rob_head = 6'($urandom);
            cdb_ready = ($urandom_range(0, 9) < 7);
            for (int p = 0; p < 4; p++) begin
                set_port(p, 1'($urandom), 6'($urandom), $urandom, 10'($urandom), 1'($urandom));
            end
            tick();
        end
        rst   = 1'b0;
        flush = 1'b0;
        req_valid = '0;
        cdb_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_age_arbiter.md
Name: cdb_age_arbiter

Overview:
- Oldest-first CDB writeback arbiter with buffering; shares one CDB among NREQ functional units (ALU, MUL, DIV, MEM).
- Each FU result is captured in a per-port one-entry holding register. The oldest held result, measured by ROB distance from the head, is moved into a registered CDB output stage.
- Sits between the FU result ports and the CDB consumers (ROB, reservation stations, PRF writeback).

Parameters:
- XLEN, 32, data width.
- NREQ, 4, number of requesting FUs; port 0 has the highest static tie priority.
- ROB_IDX_W, 6, ROB index width.
- PD_W, 10, physical destination tag width.
- STARVE_MAX, 8, non-grant cycles before a held entry is force-granted.

Ports:
- clk in 1: clock.
- rst in 1: reset, synchronous, active-high.
- flush in 1: mispredict flush; discards all buffered results.
- rob_head in ROB_IDX_W: current ROB head index.
- req_valid in NREQ: per-FU result valid.
- req_ready out NREQ: per-FU accept.
- req_value in NREQ*XLEN: packed result values; port i occupies bits [i*XLEN +: XLEN].
- req_pd in NREQ*PD_W: packed physical destination tags.
- req_rob in NREQ*ROB_IDX_W: packed ROB indices.
- req_we in NREQ: register-write enable per result.
- cdb_valid out 1: CDB output valid.
- cdb_ready in 1: consumer accept.
- cdb_value out XLEN: broadcast value.
- cdb_pd out PD_W: broadcast tag.
- cdb_rob out ROB_IDX_W: broadcast ROB index.
- cdb_we out 1: broadcast write enable.
- cdb_src out $clog2(NREQ): index of the port that produced the current CDB entry.

Behaviour:
- Reset: all hold_v = 0, out_v = 0, starvation counters = 0. cdb_valid, cdb_value, cdb_pd, cdb_rob, cdb_we, cdb_src all drive 0. req_ready is 0 during the reset cycle.
- Holding register, per port i:
  - req_ready[i] = !flush && (!hold_v[i] || grant[i]).
  - When req_valid[i] && req_ready[i], capture the payload and set hold_v[i] = 1 at the next edge.
  - A simultaneous grant and new capture on the same port is legal; the register refills.
- Output stage:
  - out_adv = !out_v || cdb_ready.
  - When out_adv and some hold_v is set, grant exactly one port. Its payload loads into the output register and out_v = 1.
  - When out_adv and no hold_v is set, out_v = 0.
  - While cdb_valid && !cdb_ready, all cdb_* outputs hold stable and no grant occurs.
- Latency: a result accepted at edge t appears on cdb_valid after edge t+1 at the earliest. Sustained throughput is 1 result per cycle.
- Age selection:
  - age_i = (req_rob_held_i - rob_head) mod 2^ROB_IDX_W, unsigned, wrap-around correct.
  - The smallest age wins; on equal age the lower port index wins.
- Starvation (when the feature is enabled):
  - cnt[i] increments, saturating at STARVE_MAX, on every out_adv cycle where hold_v[i] && !grant[i].
  - cnt[i] clears on grant or when hold_v[i] = 0.
  - Any port with cnt == STARVE_MAX overrides age selection; among multiple starved ports the lowest index wins.
- Flush:
  - At the next edge, clear all hold_v, out_v and counters.
  - req_ready is 0 in the flush cycle, and no captures occur.
  - Flush takes priority over grant and over cdb_ready.
- Reset or flush mid-stall: the stalled CDB entry is dropped; cdb_valid = 0 the following cycle.
- Invariant: no result is duplicated or lost absent flush/reset. cdb_valid only ever presents payloads that were previously accepted.

Optional Feature:
- Macro: CDB_ARB_STARVE_EN.
- Defined: starvation counters and forced grant as above.
- Undefined: counters are not built; arbitration is pure oldest-first with lower-index tie-break. STARVE_MAX is unused.

Test Plan:
- Basic latency: rob_head=0, port2 presents rob=5, value=0xDEADBEEF, pd=17, we=1, cdb_ready=1 -> cdb_valid=1 one cycle after acceptance with cdb_value=0xDEADBEEF, cdb_pd=17, cdb_rob=5, cdb_src=2.
- Age ordering with wrap: rob_head=60; ports 0,1,3 hold rob=2, 61, 63 simultaneously -> CDB order rob 61, 63, 2 on three consecutive cycles.
- Backpressure: cdb_ready=0 for 5 cycles with all 4 ports full -> cdb_* stable, req_ready=0000. Then cdb_ready=1 -> 4 results drain in 4 cycles in age order; req_ready[i] rises in the same cycle port i is granted.
- Flush mid-stall: out_v=1, 3 holds valid, cdb_ready=0, flush=1 -> next cycle cdb_valid=0, req_ready=1111. A new request after the flush appears normally.
- Starvation (CDB_ARB_STARVE_EN, STARVE_MAX=8): port3 holds rob=40, rob_head=0; port0 refills every cycle with younger-then-older rob values that always beat port3 -> port3 granted no later than the 9th output-advancing cycle after capture.
- Back-to-back refill: port1 is valid every cycle with rob=1,2,3,4 and cdb_ready=1 -> 4 consecutive CDB beats with no bubble.
